// File: rtl/hazard_issue_sched.sv
// Issue scheduler for the 4-stage in-order pipeline with one shared multi-cycle multiplier.
// Decides issue/stall/flush and registers the EX operand forwarding selects.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// RUN      | normal issue; hazards evaluated against EX/MEM/mul tracking
// LU_STALL | one bubble inserted behind a load; re-evaluates as RUN
// MUL_WAIT | ID instruction held until multiplier completion or free slot
module hazard_issue_sched #(
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use1,
  input  logic              id_use2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_we,
  input  logic              id_load,
  input  logic              id_mul,
  input  logic              ex_mispredict,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              issue,
  output logic              flush,
  output logic [1:0]        fwd1,
  output logic [1:0]        fwd2,
  output logic              mul_busy
);

  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_LU_STALL = 2'd1;
  localparam logic [1:0] S_MUL_WAIT = 2'd2;

  localparam logic [1:0] F_RF  = 2'b00;
  localparam logic [1:0] F_EX  = 2'b01;
  localparam logic [1:0] F_MEM = 2'b10;
  localparam logic [1:0] F_MUL = 2'b11;

  localparam logic [3:0] MUL_LAT_C = 4'(MUL_LAT);

  logic [1:0]        state, state_nx;

  logic              ex_v, ex_we, ex_ld;
  logic [REG_AW-1:0] ex_rd;
  logic              mem_v, mem_we, mem_ld;
  logic [REG_AW-1:0] mem_rd;

  logic [3:0]        mul_cnt;
  logic              pend_v;
  logic [REG_AW-1:0] pend_rd;

  logic [1:0]        fwd1_q, fwd2_q;

  logic issue_c, pc_en_c, ifid_en_c, flush_c;
  logic mul_done, busy_raw;
  logic ex_hit1, ex_hit2, mem_hit1, mem_hit2, mul_hit1, mul_hit2;
  logic lu_haz, mul_haz, do_issue;
  logic [1:0] sel1, sel2;

  function automatic logic reg_hit(input logic use_s, input logic [REG_AW-1:0] rs,
                                   input logic v, input logic we, input logic [REG_AW-1:0] rd);
    return use_s && (rs != '0) && v && we && (rd == rs);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic ex_h, input logic mem_h,
                                         input logic mul_h, input logic done);
    if (ex_h)              return F_EX;
    else if (mem_h)        return F_MEM;
    else if (mul_h && done) return F_MUL;
    else                   return F_RF;
  endfunction

  assign busy_raw = (mul_cnt != 4'd0);
  assign mul_done = (mul_cnt == 4'd1);

  assign ex_hit1  = reg_hit(id_use1, id_rs1, ex_v,  ex_we,  ex_rd);
  assign ex_hit2  = reg_hit(id_use2, id_rs2, ex_v,  ex_we,  ex_rd);
  assign mem_hit1 = reg_hit(id_use1, id_rs1, mem_v, mem_we, mem_rd);
  assign mem_hit2 = reg_hit(id_use2, id_rs2, mem_v, mem_we, mem_rd);
  assign mul_hit1 = reg_hit(id_use1, id_rs1, pend_v, busy_raw, pend_rd);
  assign mul_hit2 = reg_hit(id_use2, id_rs2, pend_v, busy_raw, pend_rd);

  assign lu_haz  = id_valid && ex_ld && (ex_hit1 || ex_hit2);
  // A mul result is consumable (and the unit reusable) in its completion cycle.
  assign mul_haz = id_valid && !mul_done &&
                   ((id_mul && busy_raw) || mul_hit1 || mul_hit2);

  assign sel1 = fwd_sel(ex_hit1, mem_hit1, mul_hit1, mul_done);
  assign sel2 = fwd_sel(ex_hit2, mem_hit2, mul_hit2, mul_done);

  always_comb begin
    issue_c   = 1'b0;
    pc_en_c   = 1'b0;
    ifid_en_c = 1'b0;
    flush_c   = 1'b0;
    state_nx  = state;
    if (ex_mispredict) begin
      flush_c   = 1'b1;
      pc_en_c   = 1'b1;
      ifid_en_c = 1'b1;
      state_nx  = S_RUN;
    end else begin
      case (state)
        S_RUN, S_LU_STALL, S_MUL_WAIT: begin
          if (mul_haz) begin
            state_nx = S_MUL_WAIT;
          end else if (lu_haz) begin
            state_nx = S_LU_STALL;
          end else begin
            issue_c   = 1'b1;
            pc_en_c   = 1'b1;
            ifid_en_c = 1'b1;
            state_nx  = S_RUN;
          end
        end
        default: state_nx = S_RUN;
      endcase
    end
  end

  assign do_issue = issue_c && id_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_RUN;
      ex_v    <= 1'b0;
      ex_we   <= 1'b0;
      ex_ld   <= 1'b0;
      ex_rd   <= '0;
      mem_v   <= 1'b0;
      mem_we  <= 1'b0;
      mem_ld  <= 1'b0;
      mem_rd  <= '0;
      mul_cnt <= 4'd0;
      pend_v  <= 1'b0;
      pend_rd <= '0;
      fwd1_q  <= F_RF;
      fwd2_q  <= F_RF;
    end else begin
      state  <= state_nx;
      mem_v  <= ex_v;
      mem_we <= ex_we;
      mem_ld <= ex_ld;
      mem_rd <= ex_rd;
      // Mul results bypass the EX/MEM path, so a mul never counts as an EX/MEM writer.
      ex_v   <= do_issue;
      ex_we  <= id_we && !id_mul;
      ex_ld  <= id_load;
      ex_rd  <= id_rd;
      fwd1_q <= do_issue ? sel1 : F_RF;
      fwd2_q <= do_issue ? sel2 : F_RF;
      if (do_issue && id_mul) begin
        mul_cnt <= MUL_LAT_C;
        pend_v  <= id_we && (id_rd != '0);
        pend_rd <= id_rd;
      end else begin
        if (busy_raw) mul_cnt <= mul_cnt - 4'd1;
        if (mul_done) pend_v <= 1'b0;
      end
    end
  end

  // Outputs are held low while reset is asserted.
  assign issue    = rst_n && issue_c;
  assign pc_en    = rst_n && pc_en_c;
  assign ifid_en  = rst_n && ifid_en_c;
  assign flush    = rst_n && flush_c;
  assign mul_busy = rst_n && busy_raw;
  assign fwd1     = fwd1_q;
  assign fwd2     = fwd2_q;

endmodule

// File: tb/tb_hazard_issue_sched.sv
// Scoreboard bench for hazard_issue_sched: per-cycle expected control/forwarding words
// are queued as each instruction is driven and compared when the cycle's outputs settle.
module tb_hazard_issue_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_use1, id_use2, id_we, id_load, id_mul, ex_mispredict;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       pc_en, ifid_en, issue, flush, mul_busy;
  logic [1:0] fwd1, fwd2;

  int n_chk = 0;
  int n_err = 0;
  logic [8:0] exp_q[$];

  // {issue, pc_en, ifid_en, flush, mul_busy}
  localparam logic [4:0] ISS = 5'b11100;
  localparam logic [4:0] ISB = 5'b11101;
  localparam logic [4:0] STL = 5'b00000;
  localparam logic [4:0] STB = 5'b00001;
  localparam logic [4:0] FLS = 5'b01110;
  // {fwd1, fwd2}
  localparam logic [3:0] F00 = 4'b0000;
  localparam logic [3:0] F1X = 4'b0100;
  localparam logic [3:0] F1M = 4'b1000;
  localparam logic [3:0] F1U = 4'b1100;

  always #5 clk = ~clk;

  hazard_issue_sched #(.REG_AW(5), .MUL_LAT(3)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
    .id_rd(id_rd), .id_we(id_we), .id_load(id_load), .id_mul(id_mul),
    .ex_mispredict(ex_mispredict),
    .pc_en(pc_en), .ifid_en(ifid_en), .issue(issue), .flush(flush),
    .fwd1(fwd1), .fwd2(fwd2), .mul_busy(mul_busy)
  );

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got {iss,pc,ifid,fl,busy,fwd1,fwd2}=%b required=%b", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input bit chk, input bit rst, input bit v,
                      input int rs1, input int rs2, input int rd,
                      input bit we, input bit ld, input bit mul, input bit mp,
                      input logic [4:0] ctl, input logic [3:0] fw);
    logic [8:0] e;
    @(posedge clk);
    #1;
    rst_n = rst; id_valid = v;
    id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_rd = 5'(rd);
    id_use1 = v; id_use2 = v;
    id_we = we; id_load = ld; id_mul = mul; ex_mispredict = mp;
    if (chk) exp_q.push_back({ctl, fw});
    @(negedge clk);
    if (chk) begin
      e = exp_q.pop_front();
      check(tag, {issue, pc_en, ifid_en, flush, mul_busy, fwd1, fwd2}, e);
    end
  endtask

  task automatic bubble(input string tag, input logic [4:0] ctl, input logic [3:0] fw);
    step(tag, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, ctl, fw);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; id_valid = 1'b0; id_use1 = 1'b0; id_use2 = 1'b0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_we = 1'b0; id_load = 1'b0; id_mul = 1'b0; ex_mispredict = 1'b0;

    step("rst0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, STL, F00);
    step("rst1", 1, 0, 1, 1, 2, 3, 1, 0, 0, 0, STL, F00);

    // 1: ALU RAW back-to-back forwards from EX/MEM
    step("t1_add", 1, 1, 1, 1, 2, 3, 1, 0, 0, 0, ISS, F00);
    step("t1_sub", 1, 1, 1, 3, 1, 4, 1, 0, 0, 0, ISS, F00);
    bubble("t1_fwd", ISS, F1X);

    // 2: load-use: one stall cycle then MEM/WB forward
    step("t2_lw",    1, 1, 1, 2, 0, 5, 1, 1, 0, 0, ISS, F00);
    step("t2_stall", 1, 1, 1, 5, 0, 6, 1, 0, 0, 0, STL, F00);
    step("t2_iss",   1, 1, 1, 5, 0, 6, 1, 0, 0, 0, ISS, F00);
    bubble("t2_fwd", ISS, F1M);

    // 3: mul RAW stalls until completion, forwards mul result
    step("t3_mul", 1, 1, 1, 1, 2, 7, 1, 0, 1, 0, ISS, F00);
    step("t3_st1", 1, 1, 1, 7, 0, 8, 1, 0, 0, 0, STB, F00);
    step("t3_st2", 1, 1, 1, 7, 0, 8, 1, 0, 0, 0, STB, F00);
    step("t3_iss", 1, 1, 1, 7, 0, 8, 1, 0, 0, 0, ISB, F00);
    bubble("t3_fwd", ISS, F1U);

    // 4: structural mul-mul: busy spans 6 cycles
    step("t4_mul1", 1, 1, 1, 1, 2, 9,  1, 0, 1, 0, ISS, F00);
    step("t4_st1",  1, 1, 1, 3, 4, 10, 1, 0, 1, 0, STB, F00);
    step("t4_st2",  1, 1, 1, 3, 4, 10, 1, 0, 1, 0, STB, F00);
    step("t4_mul2", 1, 1, 1, 3, 4, 10, 1, 0, 1, 0, ISB, F00);
    bubble("t4_b1", ISB, F00);
    bubble("t4_b2", ISB, F00);
    bubble("t4_b3", ISB, F00);
    bubble("t4_free", ISS, F00);

    // 5: mispredict during load-use stall
    step("t5_lw",    1, 1, 1, 1, 0, 11, 1, 1, 0, 0, ISS, F00);
    step("t5_stall", 1, 1, 1, 11, 0, 12, 1, 0, 0, 0, STL, F00);
    step("t5_flush", 1, 1, 1, 11, 0, 12, 1, 0, 0, 1, FLS, F00);
    step("t5_run",   1, 1, 1, 11, 0, 13, 1, 0, 0, 0, ISS, F00);
    bubble("t5_b", ISS, F00);

    // 6: reset in the middle of MUL_WAIT
    step("t6_mul",  1, 1, 1, 1, 2, 14, 1, 0, 1, 0, ISS, F00);
    step("t6_wait", 1, 1, 1, 14, 0, 15, 1, 0, 0, 0, STB, F00);
    step("t6_rsta", 0, 0, 1, 14, 0, 15, 1, 0, 0, 0, STL, F00);
    step("t6_rst",  1, 0, 1, 14, 0, 15, 1, 0, 0, 0, STL, F00);
    step("t6_add",  1, 1, 1, 14, 0, 15, 1, 0, 0, 0, ISS, F00);
    bubble("t6_fwd", ISS, F00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
